design_4x4: RTL and testbench

- Synthesizable behavioural model of a 4x4 NoC mesh fronted by two AXI4-Lite master network adapters (MNA_0 at node (0,0), MNA_1 at node (3,3)).
- Two memory slave nodes, each holding 16 x 32-bit registers:
  - MEM_A at node (0,3), addr[31]=0, base 0x7000_0000.
  - MEM_B at node (3,0), addr[31]=1, base 0xF000_0000.
- Both masters can read and write both memories. The mesh is modelled as a fixed per-direction latency, because every master-to-memory path is 3 XY hops.

---
 rtl/design_4x4_pkg.sv | 34 +++
 rtl/design_4x4_mna.sv | 149 ++++++++++++++
 rtl/design_4x4.sv | 109 ++++++++++
 tb/tb_design_4x4.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/design_4x4_pkg.sv
// Shared constants and types for the 4x4 mesh model with two AXI4-Lite master adapters.
// Network latency is derived from the hop count, so it cannot be set independently.
package design_4x4_pkg;

  localparam int HOP_LAT = 2;
  localparam int HOPS    = 3;
  localparam int NET_LAT = HOPS * HOP_LAT;
  localparam int CNT_W   = $clog2(NET_LAT);

  localparam logic [31:0] MEM_A_BASE = 32'h7000_0000;
  localparam logic [31:0] MEM_B_BASE = 32'hF000_0000;
  localparam int          SEL_BIT    = 31;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACCESS,
    RSP,
    RESP_HOLD
  } mna_state_t;

  // One-cycle memory access request from an adapter to the arbiter.
  typedef struct packed {
    logic        req;
    logic        sel;
    logic [3:0]  idx;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/design_4x4_mna.sv
// AXI4-Lite slave front end of one master network adapter.
// It accepts one transaction, waits out the mesh latency both ways, and holds the response.
import design_4x4_pkg::*;

module mna_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output mem_req_t    mem_req,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata
);

  mna_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_write_q, is_write_d;
  logic             sel_q, sel_d;
  logic [3:0]       idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_pending;
  logic             unused_bits;

  // Only the memory select bit and word index matter; the rest of the address and prot are ignored.
  assign unused_bits = ^{awaddr[30:6], awaddr[1:0], awprot,
                         araddr[30:6], araddr[1:0], arprot};

  assign wr_pending = awvalid && wvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      sel_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (wr_pending) begin
          is_write_d = 1'b1;
          sel_d      = (awaddr[SEL_BIT] == MEM_B_BASE[SEL_BIT]);
          idx_d      = awaddr[5:2];
          wdata_d    = wdata;
          wstrb_d    = wstrb;
          cnt_d      = '0;
          state_d    = REQ;
        end else if (arvalid) begin
          is_write_d = 1'b0;
          sel_d      = (araddr[SEL_BIT] == MEM_B_BASE[SEL_BIT]);
          idx_d      = araddr[5:2];
          cnt_d      = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (cnt_q == CNT_W'(NET_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACCESS: begin
        if (mem_gnt) begin
          if (!is_write_q) begin
            rdata_d = mem_rdata;
          end
          cnt_d   = '0;
          state_d = RSP;
        end
      end
      RSP: begin
        if (cnt_q == CNT_W'(NET_LAT - 1)) begin
          cnt_d   = '0;
          state_d = RESP_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP_HOLD: begin
        if (is_write_q ? bready : rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    awready       = (state_q == IDLE) && wr_pending;
    wready        = (state_q == IDLE) && wr_pending;
    arready       = (state_q == IDLE) && arvalid && !wr_pending;
    bvalid        = (state_q == RESP_HOLD) && is_write_q;
    rvalid        = (state_q == RESP_HOLD) && !is_write_q;
    bresp         = RESP_OKAY;
    rresp         = RESP_OKAY;
    rdata         = rdata_q;
    mem_req.req   = (state_q == ACCESS);
    mem_req.sel   = sel_q;
    mem_req.idx   = idx_q;
    mem_req.we    = is_write_q;
    mem_req.wdata = wdata_q;
    mem_req.wstrb = wstrb_q;
  end

endmodule

// File: rtl/design_4x4.sv
// Top of the 4x4 mesh model: two adapters, two 16-word memories and a fixed-priority arbiter.
// Index 0 of the memory array is MEM_A (addr[31]=0), index 1 is MEM_B.
import design_4x4_pkg::*;

module design_4x4 (
  input  logic        clk_0,
  input  logic        rst_0,
  input  logic [31:0] s0_awaddr,
  input  logic [2:0]  s0_awprot,
  input  logic        s0_awvalid,
  output logic        s0_awready,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  input  logic        s0_wvalid,
  output logic        s0_wready,
  output logic [1:0]  s0_bresp,
  output logic        s0_bvalid,
  input  logic        s0_bready,
  input  logic [31:0] s0_araddr,
  input  logic [2:0]  s0_arprot,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  input  logic [31:0] s1_awaddr,
  input  logic [2:0]  s1_awprot,
  input  logic        s1_awvalid,
  output logic        s1_awready,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  input  logic        s1_wvalid,
  output logic        s1_wready,
  output logic [1:0]  s1_bresp,
  output logic        s1_bvalid,
  input  logic        s1_bready,
  input  logic [31:0] s1_araddr,
  input  logic [2:0]  s1_arprot,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  output logic        s1_rvalid,
  input  logic        s1_rready
);

  logic [1:0][15:0][31:0] mem_q, mem_d;
  mem_req_t               req_0, req_1;
  logic                   gnt_0, gnt_1;
  logic [31:0]            rdata_0, rdata_1;

  mna_port u_mna_0 (
    .clk(clk_0), .rst(rst_0),
    .awaddr(s0_awaddr), .awprot(s0_awprot), .awvalid(s0_awvalid), .awready(s0_awready),
    .wdata(s0_wdata), .wstrb(s0_wstrb), .wvalid(s0_wvalid), .wready(s0_wready),
    .bresp(s0_bresp), .bvalid(s0_bvalid), .bready(s0_bready),
    .araddr(s0_araddr), .arprot(s0_arprot), .arvalid(s0_arvalid), .arready(s0_arready),
    .rdata(s0_rdata), .rresp(s0_rresp), .rvalid(s0_rvalid), .rready(s0_rready),
    .mem_req(req_0), .mem_gnt(gnt_0), .mem_rdata(rdata_0)
  );

  mna_port u_mna_1 (
    .clk(clk_0), .rst(rst_0),
    .awaddr(s1_awaddr), .awprot(s1_awprot), .awvalid(s1_awvalid), .awready(s1_awready),
    .wdata(s1_wdata), .wstrb(s1_wstrb), .wvalid(s1_wvalid), .wready(s1_wready),
    .bresp(s1_bresp), .bvalid(s1_bvalid), .bready(s1_bready),
    .araddr(s1_araddr), .arprot(s1_arprot), .arvalid(s1_arvalid), .arready(s1_arready),
    .rdata(s1_rdata), .rresp(s1_rresp), .rvalid(s1_rvalid), .rready(s1_rready),
    .mem_req(req_1), .mem_gnt(gnt_1), .mem_rdata(rdata_1)
  );

  // MNA_0 wins a same-memory collision; MNA_1 simply retries from ACCESS next cycle.
  always_comb begin
    gnt_0 = req_0.req;
    gnt_1 = req_1.req && !(req_0.req && (req_0.sel == req_1.sel));
  end

  // Reads see the pre-edge contents, so a read never observes a same-cycle write.
  assign rdata_0 = mem_q[req_0.sel][req_0.idx];
  assign rdata_1 = mem_q[req_1.sel][req_1.idx];

  always_comb begin
    mem_d = mem_q;
    if (gnt_0 && req_0.we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_0.wstrb[b]) begin
          mem_d[req_0.sel][req_0.idx][8*b +: 8] = req_0.wdata[8*b +: 8];
        end
      end
    end
    if (gnt_1 && req_1.we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_1.wstrb[b]) begin
          mem_d[req_1.sel][req_1.idx][8*b +: 8] = req_1.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst_0) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_design_4x4.sv
// Bench for design_4x4: directed scenarios plus random traffic checked against a word-array model.
// Cycle stamps are taken at falling edges; a handshake stamp is the cycle its ready was seen high.
import design_4x4_pkg::*;

module tb_design_4x4;

  localparam int EXP_LAT = 2 * HOPS * HOP_LAT + 2;

  logic clk_0 = 1'b0;
  logic rst_0 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0][31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [1:0][2:0]  awprot = '0, arprot = '0;
  logic [1:0][3:0]  wstrb = '0;
  logic [1:0]       awvalid = '0, wvalid = '0, arvalid = '0;
  logic [1:0]       bready = '1, rready = '1;
  wire  [1:0]       awready, wready, arready, bvalid, rvalid;
  wire  [1:0][1:0]  bresp, rresp;
  wire  [1:0][31:0] rdata;

  logic [31:0] ref_mem [2][16];

  design_4x4 dut (
    .clk_0(clk_0), .rst_0(rst_0),
    .s0_awaddr(awaddr[0]), .s0_awprot(awprot[0]), .s0_awvalid(awvalid[0]), .s0_awready(awready[0]),
    .s0_wdata(wdata[0]), .s0_wstrb(wstrb[0]), .s0_wvalid(wvalid[0]), .s0_wready(wready[0]),
    .s0_bresp(bresp[0]), .s0_bvalid(bvalid[0]), .s0_bready(bready[0]),
    .s0_araddr(araddr[0]), .s0_arprot(arprot[0]), .s0_arvalid(arvalid[0]), .s0_arready(arready[0]),
    .s0_rdata(rdata[0]), .s0_rresp(rresp[0]), .s0_rvalid(rvalid[0]), .s0_rready(rready[0]),
    .s1_awaddr(awaddr[1]), .s1_awprot(awprot[1]), .s1_awvalid(awvalid[1]), .s1_awready(awready[1]),
    .s1_wdata(wdata[1]), .s1_wstrb(wstrb[1]), .s1_wvalid(wvalid[1]), .s1_wready(wready[1]),
    .s1_bresp(bresp[1]), .s1_bvalid(bvalid[1]), .s1_bready(bready[1]),
    .s1_araddr(araddr[1]), .s1_arprot(arprot[1]), .s1_arvalid(arvalid[1]), .s1_arready(arready[1]),
    .s1_rdata(rdata[1]), .s1_rresp(rresp[1]), .s1_rvalid(rvalid[1]), .s1_rready(rready[1])
  );

  always #5 clk_0 = ~clk_0;
  always @(posedge clk_0) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) ref_mem[s][i] = 32'h0;
  endfunction

  // Memory is chosen by the top address bit; the word is the byte address divided by 4, modulo 16.
  function automatic void model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    int m = addr[31] ? 1 : 0;
    int w = int'((addr >> 2) % 16);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[m][w][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return ref_mem[addr[31] ? 1 : 0][int'((addr >> 2) % 16)];
  endfunction

  task automatic send_write(input int m, input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] s, output int t);
    t = -1;
    @(posedge clk_0); #1;
    awaddr[m] = addr; awprot[m] = 3'($urandom); wdata[m] = d; wstrb[m] = s;
    awvalid[m] = 1'b1; wvalid[m] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_0);
      if (awready[m] && wready[m]) begin t = cyc; break; end
    end
    @(posedge clk_0); #1;
    awvalid[m] = 1'b0; wvalid[m] = 1'b0;
  endtask

  task automatic wait_b(input int m, output int when, output logic [1:0] resp);
    when = -1; resp = 'x;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_0);
      if (bvalid[m]) begin when = cyc; resp = bresp[m]; break; end
    end
    if (when >= 0) begin @(posedge clk_0); #1; end
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic [1:0] resp);
    int t, when;
    send_write(m, addr, d, s, t);
    wait_b(m, when, resp);
    lat = (t >= 0 && when >= 0) ? when - t : -1;
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, input int hold,
                         output logic [31:0] d, output logic [1:0] resp, output int lat, output bit stable);
    int t = -1;
    int when = -1;
    d = 'x; resp = 'x; lat = -1; stable = 1'b1;
    @(posedge clk_0); #1;
    rready[m] = (hold == 0); araddr[m] = addr; arprot[m] = 3'($urandom); arvalid[m] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_0);
      if (arready[m]) begin t = cyc; break; end
    end
    @(posedge clk_0); #1;
    arvalid[m] = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_0);
      if (rvalid[m]) begin when = cyc; break; end
    end
    if (t >= 0 && when >= 0) begin
      lat = when - t; d = rdata[m]; resp = rresp[m];
      repeat (hold) begin
        @(negedge clk_0);
        if (rvalid[m] !== 1'b1 || rdata[m] !== d) stable = 1'b0;
      end
      if (hold > 0) begin
        @(posedge clk_0); #1 rready[m] = 1'b1;
        @(negedge clk_0);
        if (rvalid[m] !== 1'b1 || rdata[m] !== d) stable = 1'b0;
      end
      @(posedge clk_0); #1;
    end
    rready[m] = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat; bit st;
    rst_0 = 1'b1;
    repeat (20) @(posedge clk_0);
    #1 rst_0 = 1'b0;
    model_clear();
    @(negedge clk_0);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 10'b0) begin
      errors++; $display("[TB] FAIL reset_handshake: got %b required 0", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if (rdata !== 64'h0 || bresp !== 4'h0 || rresp !== 4'h0) begin
      errors++; $display("[TB] FAIL reset_data: rdata %h bresp %b rresp %b required all 0", rdata, bresp, rresp);
    end
    do_read(0, 32'hF000_0008, 0, d, r, lat, st);
    checks++;
    if (d !== 32'h0 || r !== RESP_OKAY) begin
      errors++; $display("[TB] FAIL reset_read: got %h/%b required 00000000/00", d, r);
    end
  endtask

  task automatic test_cross(input int wm, input logic [31:0] base, input logic [31:0] vals [3]);
    logic [31:0] d; logic [1:0] r; int lat; bit st;
    for (int i = 0; i < 3; i++) begin
      do_write(wm, base + 32'(4*i), vals[i], 4'hF, lat, r);
      model_write(base + 32'(4*i), vals[i], 4'hF);
      checks++;
      if (r !== RESP_OKAY) begin
        errors++; $display("[TB] FAIL cross_bresp m%0d w%0d: got %b required 00", wm, i, r);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_read(1 - wm, base + 32'(4*i), 0, d, r, lat, st);
      checks++;
      if (d !== model_read(base + 32'(4*i)) || r !== RESP_OKAY) begin
        errors++; $display("[TB] FAIL cross_read m%0d w%0d: got %h/%b required %h/00",
                           1 - wm, i, d, r, model_read(base + 32'(4*i)));
      end
    end
  endtask

  task automatic test_latency_backpressure();
    logic [31:0] d; logic [1:0] r; int lat; bit st;
    do_write(0, MEM_B_BASE + 32'hC, 32'hC0FF_EE00, 4'hF, lat, r);
    model_write(MEM_B_BASE + 32'hC, 32'hC0FF_EE00, 4'hF);
    checks++;
    if (lat !== EXP_LAT) begin
      errors++; $display("[TB] FAIL write_latency: got %0d required %0d", lat, EXP_LAT);
    end
    do_read(1, MEM_B_BASE + 32'hC, 5, d, r, lat, st);
    checks++;
    if (lat !== EXP_LAT) begin
      errors++; $display("[TB] FAIL read_latency: got %0d required %0d", lat, EXP_LAT);
    end
    checks++;
    if (st !== 1'b1 || d !== model_read(MEM_B_BASE + 32'hC)) begin
      errors++; $display("[TB] FAIL read_hold: stable %0d data %h required 1 %h", st, d, model_read(MEM_B_BASE + 32'hC));
    end
    @(negedge clk_0);
    checks++;
    if (rvalid[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL rvalid_drop: got %b required 0", rvalid[1]);
    end
  endtask

  task automatic test_contention();
    int t0, t1, w0, w1;
    logic [1:0] r0, r1;
    logic [31:0] d; logic [1:0] r; int lat; bit st;
    fork
      begin send_write(0, 32'h7000_0004, 32'hAAAA_AAAA, 4'hF, t0); wait_b(0, w0, r0); end
      begin send_write(1, 32'h7000_0004, 32'h5555_5555, 4'hF, t1); wait_b(1, w1, r1); end
    join
    model_write(32'h7000_0004, 32'hAAAA_AAAA, 4'hF);
    model_write(32'h7000_0004, 32'h5555_5555, 4'hF);
    checks++;
    if (t0 < 0 || t0 !== t1 || w0 - t0 !== EXP_LAT || w1 - w0 !== 1) begin
      errors++; $display("[TB] FAIL contention_timing: hs %0d/%0d b %0d/%0d required same hs, b0=hs+%0d, b1=b0+1",
                         t0, t1, w0, w1, EXP_LAT);
    end
    do_read(0, 32'h7000_0004, 0, d, r, lat, st);
    checks++;
    if (d !== 32'h5555_5555) begin
      errors++; $display("[TB] FAIL contention_data: got %h required 55555555", d);
    end
    fork
      begin send_write(0, 32'h7000_0018, 32'h0A0A_0A0A, 4'hF, t0); wait_b(0, w0, r0); end
      begin send_write(1, 32'hF000_0018, 32'h0B0B_0B0B, 4'hF, t1); wait_b(1, w1, r1); end
    join
    model_write(32'h7000_0018, 32'h0A0A_0A0A, 4'hF);
    model_write(32'hF000_0018, 32'h0B0B_0B0B, 4'hF);
    checks++;
    if (t0 < 0 || t1 < 0 || w0 - t0 !== EXP_LAT || w1 - t1 !== EXP_LAT) begin
      errors++; $display("[TB] FAIL concurrent_timing: lat %0d/%0d required %0d", w0 - t0, w1 - t1, EXP_LAT);
    end
    do_read(1, 32'h7000_0018, 0, d, r, lat, st);
    checks++;
    if (d !== model_read(32'h7000_0018)) begin
      errors++; $display("[TB] FAIL concurrent_data: got %h required %h", d, model_read(32'h7000_0018));
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; int lat; bit st;
    do_write(1, 32'h7000_0008, 32'hFFFF_FFFF, 4'b0010, lat, r);
    model_write(32'h7000_0008, 32'hFFFF_FFFF, 4'b0010);
    do_read(0, 32'h7000_0008, 0, d, r, lat, st);
    checks++;
    if (d !== 32'h3300_FF33 || d !== model_read(32'h7000_0008)) begin
      errors++; $display("[TB] FAIL strobe_merge: got %h required 3300ff33", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, addr, exp; logic [1:0] r; int lat, m; bit st;
    logic [3:0] s;
    for (int k = 0; k < 24; k++) begin
      m = int'($urandom_range(0, 1));
      addr = {1'($urandom), 25'($urandom), 4'($urandom), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        do_write(m, addr, d, s, lat, r);
        model_write(addr, d, s);
        checks++;
        if (lat !== EXP_LAT || r !== RESP_OKAY) begin
          errors++; $display("[TB] FAIL rand_write %0d: lat %0d resp %b required %0d 00", k, lat, r, EXP_LAT);
        end
      end else begin
        exp = model_read(addr);
        do_read(m, addr, 0, d, r, lat, st);
        checks++;
        if (d !== exp || lat !== EXP_LAT) begin
          errors++; $display("[TB] FAIL rand_read %0d addr %h: got %h lat %0d required %h lat %0d",
                             k, addr, d, lat, exp, EXP_LAT);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int t; bit seen = 1'b0;
    logic [31:0] d; logic [1:0] r; int lat; bit st;
    send_write(0, 32'h7000_000C, 32'hDEAD_BEEF, 4'hF, t);
    repeat (3) @(posedge clk_0);
    #1 rst_0 = 1'b1;
    repeat (2) @(posedge clk_0);
    #1 rst_0 = 1'b0;
    model_clear();
    repeat (25) begin
      @(negedge clk_0);
      if (bvalid[0] || bvalid[1]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL midflight_resp: got bvalid 1 required 0");
    end
    do_read(1, 32'h7000_0004, 0, d, r, lat, st);
    checks++;
    if (d !== model_read(32'h7000_0004)) begin
      errors++; $display("[TB] FAIL midflight_mem_a: got %h required %h", d, model_read(32'h7000_0004));
    end
    do_read(0, MEM_B_BASE, 0, d, r, lat, st);
    checks++;
    if (d !== model_read(MEM_B_BASE)) begin
      errors++; $display("[TB] FAIL midflight_mem_b: got %h required %h", d, model_read(MEM_B_BASE));
    end
  endtask

  initial begin
    logic [31:0] va [3];
    logic [31:0] vb [3];
    va = '{32'h1100_0011, 32'h2200_0022, 32'h3300_0033};
    vb = '{32'h1111_1111, 32'h2211_1122, 32'h3311_1133};
    $display("[TB] start");
    test_reset();
    test_cross(0, MEM_A_BASE, va);
    test_cross(1, MEM_B_BASE, vb);
    test_latency_backpressure();
    test_contention();
    test_strobe();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
